// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32 x 32 RISC-V integer register file, two registered read
// ports and one write port. x0 reads as zero; a write and a read of the same
// index at one edge return the new write data.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; clears registers and read data
//   re     - read enable; 0 holds rd1/rd2 (stall)
//   ra1    - read address, port 1 (operand mux input A)
//   ra2    - read address, port 2 (forwarding/immediate path, mux input B)
//   we     - write enable
//   wa     - write address
//   wd     - write data
//   rd1    - registered read data, port 1
//   rd2    - registered read data, port 2
module reg_file_2r1w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en_c;
  logic [DATA_W-1:0] rd1_next_c;
  logic [DATA_W-1:0] rd2_next_c;

  // Writes to x0 are dropped so mem[0] stays at its reset value of zero.
  assign wr_en_c = we && (wa != '0);

  // Read value with x0 forced to zero and same-edge write bypass.
  function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a == '0) begin
      v = '0;
    end else if (wr_en_c && (wa == a)) begin
      v = wd;
    end else begin
      v = mem[a];
    end
    return v;
  endfunction

  // Next read data; both ports resolve through the same path so ra1==ra2
  // always yields identical results.
  always_comb begin
    rd1_next_c = '0;
    rd2_next_c = '0;
    rd1_next_c = read_value(ra1);
    rd2_next_c = read_value(ra2);
  end

  // Register array; reset clears every entry so no X can ever be read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en_c) begin
      mem[wa] <= wd;
    end
  end

  // Read data registers; held while re is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1 <= '0;
      rd2 <= '0;
    end else if (re) begin
      rd1 <= rd1_next_c;
      rd2 <= rd2_next_c;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Testbench for reg_file_2r1w: directed vectors, expected read data pushed
// into a queue by the driver and compared by an independent monitor after
// every rising clock edge and every asynchronous reset assertion.
module tb_reg_file_2r1w;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e2;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              re = 1'b1;
  logic [ADDR_W-1:0] ra1 = 5'd5;
  logic [ADDR_W-1:0] ra2 = 5'd31;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] wa = '0;
  logic [DATA_W-1:0] wd = '0;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

  reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .re   (re),
    .ra1  (ra1),
    .ra2  (ra2),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 ns");
    $fatal(1, "timeout");
  end

  // Monitor: one expectation per rising edge and per reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: output event at %0t with no expectation queued", $time);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (rd1 !== e.e1 || rd2 !== e.e2) begin
            n_bad++;
            $display("FAIL %s: rd1=%h rd2=%h, required rd1=%h rd2=%h",
                     e.name, rd1, rd2, e.e1, e.e2);
          end
        end
      end
    end
  end

  task automatic push(input string name, input logic [DATA_W-1:0] e1,
                      input logic [DATA_W-1:0] e2);
    exp_t e;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    exp_q.push_back(e);
  endtask

  // One clock cycle of stimulus, applied at the falling edge, with the read
  // data expected after the following rising edge.
  task automatic step(input string name, input logic r, input logic rd_en,
                      input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                      input logic w, input logic [ADDR_W-1:0] wadr,
                      input logic [DATA_W-1:0] wdat,
                      input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
    @(negedge clk);
    rst_n = r;
    re    = rd_en;
    ra1   = a1;
    ra2   = a2;
    we    = w;
    wa    = wadr;
    wd    = wdat;
    push(name, e1, e2);
  endtask

  initial begin
    // Reset held with a live read request.
    push("rst_hold0", 32'h0, 32'h0);
    @(posedge clk);
    step("rst_hold1",      1'b0, 1'b1, 5'd5,  5'd31, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0);
    step("rst_first_read", 1'b1, 1'b1, 5'd5,  5'd31, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0);
    // Write then read.
    step("wr3_rd_other",   1'b1, 1'b1, 5'd5,  5'd31, 1'b1, 5'd3,  32'h0F0F0F0F, 32'h0,        32'h0);
    step("wr_then_rd",     1'b1, 1'b1, 5'd3,  5'd3,  1'b0, 5'd0,  32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F);
    // x0 hardwire, same cycle as the write and later.
    step("x0_same_cycle",  1'b1, 1'b1, 5'd0,  5'd3,  1'b1, 5'd0,  32'hF0F0F0F0, 32'h0,        32'h0F0F0F0F);
    step("x0_later",       1'b1, 1'b1, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        32'h0);
    // Bypass on port 1 and port 2 together.
    step("wr7",            1'b1, 1'b1, 5'd3,  5'd0,  1'b1, 5'd7,  32'h11111111, 32'h0F0F0F0F, 32'h0);
    step("rd7_old",        1'b1, 1'b1, 5'd7,  5'd7,  1'b1, 5'd9,  32'hAAAAAAAA, 32'h11111111, 32'h11111111);
    step("bypass_same_edge", 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7,  32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0);
    step("post_bypass",    1'b1, 1'b1, 5'd7,  5'd9,  1'b0, 5'd0,  32'h0,        32'hF0F0F0F0, 32'hAAAAAAAA);
    step("rd3_again",      1'b1, 1'b1, 5'd3,  5'd3,  1'b0, 5'd0,  32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F);
    // Stall: outputs hold while the write still commits.
    step("stall_hold0",    1'b1, 1'b0, 5'd9,  5'd7,  1'b1, 5'd3,  32'h12345678, 32'h0F0F0F0F, 32'h0F0F0F0F);
    step("stall_hold1",    1'b1, 1'b0, 5'd9,  5'd7,  1'b0, 5'd0,  32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F);
    step("stall_release",  1'b1, 1'b1, 5'd3,  5'd9,  1'b0, 5'd0,  32'h0,        32'h12345678, 32'hAAAAAAAA);
    step("bypass_port2",   1'b1, 1'b1, 5'd9,  5'd31, 1'b1, 5'd31, 32'hCAFEF00D, 32'hAAAAAAAA, 32'hCAFEF00D);
    step("rd31_top",       1'b1, 1'b1, 5'd31, 5'd7,  1'b0, 5'd0,  32'h0,        32'hCAFEF00D, 32'hF0F0F0F0);

    // Async reset 3 ns before an edge that carries a write to x4.
    @(negedge clk);
    we  = 1'b1;
    wa  = 5'd4;
    wd  = 32'hDEADBEEF;
    re  = 1'b1;
    ra1 = 5'd4;
    ra2 = 5'd31;
    #2;
    push("async_rst_immediate", 32'h0, 32'h0);
    push("async_rst_edge",      32'h0, 32'h0);
    rst_n = 1'b0;
    step("async_rst_hold",   1'b0, 1'b1, 5'd4, 5'd31, 1'b1, 5'd4, 32'hDEADBEEF, 32'h0, 32'h0);
    step("rd4_after_rst",    1'b1, 1'b1, 5'd4, 5'd31, 1'b0, 5'd0, 32'h0,        32'h0, 32'h0);
    step("rd3_after_rst",    1'b1, 1'b1, 5'd3, 5'd7,  1'b0, 5'd0, 32'h0,        32'h0, 32'h0);
    step("wr4_bypass",       1'b1, 1'b1, 5'd4, 5'd0,  1'b1, 5'd4, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h0);
    step("rd4_stored",       1'b1, 1'b1, 5'd4, 5'd4,  1'b0, 5'd0, 32'h0,        32'h5A5A5A5A, 32'h5A5A5A5A);

    @(negedge clk);
    done = 1'b1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry x 32-bit RISC-V integer register file with two read ports and one write port.
- Sits directly upstream of the 2:1 operand-select mux. Read port 1 drives mux input A (rs1 operand).
- Read port 2 feeds the forwarding/immediate path that drives mux input B.
- Reads are registered (1-cycle latency) with hold-on-stall and same-cycle write bypass. x0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- re  input  1  read enable; 0 = hold rd1/rd2 (pipeline stall).
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- we  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- rd1  output  DATA_W  registered read data, port 1 (to mux A).
- rd2  output  DATA_W  registered read data, port 2 (to mux B path).

Behaviour:
- Single clock domain, one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n=0 immediately clears all 32 registers, rd1 and rd2 to 0. No clock is needed.
  - Deassertion is sampled at the next rising edge. The first legal write or read happens on the first rising edge with rst_n=1.
- Write:
  - At a rising edge with we=1 and wa!=0, mem[wa] <= wd.
  - A write with wa=0 is discarded; mem[0] always reads 0.
- Read:
  - At a rising edge with re=1:
    - rd1 <= value(ra1)
    - rd2 <= value(ra2)
  - value(a) is defined as follows:
    - a=0: 0.
    - we=1 and wa==a (a!=0) in the same edge: wd (bypass, new data).
    - otherwise: mem[a].
  - Read latency is 1 cycle: address presented in cycle N appears on rd1/rd2 after edge N.
- Stall: re=0 holds rd1/rd2 at their previous values. Writes still commit during a stall.
- Simultaneous events:
  - ra1==ra2: both ports return the identical value, including bypassed data.
  - Write and read to the same index in one edge return new data via bypass, never stale data.
  - Write to x0 with read of x0 in one edge returns 0.
- Reset mid-operation: rst_n asserted in any cycle aborts any pending write at that edge. All contents are lost and outputs go to 0 asynchronously.
- No X propagation: outputs are never X after reset, regardless of address inputs.
- Widths: all addresses are ADDR_W wide; no out-of-range index is possible.

Test Plan:
- Reset clear: hold rst_n=0 with re=1, ra1=5, ra2=31 for 2 cycles, then release. Required: rd1=0 and rd2=0 during reset; both remain 0 on the first read after release.
- Write then read:
  - Stimulus: we=1, wa=3, wd=32'h0F0F0F0F; next cycle we=0, ra1=3, ra2=3, re=1.
  - Required: rd1=rd2=32'h0F0F0F0F one cycle later.
- x0 hardwire:
  - Stimulus: we=1, wa=0, wd=32'hF0F0F0F0; then ra1=0.
  - Required: rd1=0, both in the same cycle as the write and on all later cycles.
- Bypass:
  - Stimulus: mem[7]=32'h11111111; at one edge, we=1, wa=7, wd=32'hF0F0F0F0 with ra1=7, re=1.
  - Required: after that edge rd1=32'hF0F0F0F0, not 32'h11111111.
- Stall hold:
  - Stimulus: rd1 currently 32'h0F0F0F0F. Set re=0, ra1=9 (mem[9]=32'hAAAAAAAA), and write wa=3, wd=32'h12345678.
  - Required: rd1 stays 32'h0F0F0F0F while re=0.
  - Then re=1, ra1=3. Required: rd1=32'h12345678.
- Async reset mid-write:
  - Stimulus: we=1, wa=4, wd=32'hDEADBEEF; drop rst_n low 3 ns before the clock edge.
  - Required: rd1/rd2 go to 0 immediately. After release, a read of register 4 returns 0.
